// File: rtl/mac_param_scheduler_if.sv
// rtl/mac_param_scheduler_if.sv - command handshake bundle between front end and MAC parameter scheduler
interface mac_param_scheduler_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [47:0] cmd_start_time;
    logic [47:0] cmd_freq;
    logic [13:0] cmd_phase;

    modport master (
        output cmd_valid,
        output cmd_start_time,
        output cmd_freq,
        output cmd_phase,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_start_time,
        input  cmd_freq,
        input  cmd_phase,
        output cmd_ready
    );
endinterface

// File: rtl/mac_param_scheduler.sv
// rtl/mac_param_scheduler.sv - timestamp counter plus FIFO of timed (start_time, freq, phase) sets driving the phase MAC
module mac_param_scheduler #(
    parameter  int DEPTH  = 4,
    parameter  int LATE_W = 16,
    localparam int LVL_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 ts_run_i,
    input  logic                 ts_clear_i,
    input  logic                 flush_i,
    mac_param_scheduler_if.slave cmd,
    output logic [47:0]          timestamp_o,
    output logic [47:0]          mac_timeoffset_o,
    output logic [47:0]          mac_freq_o,
    output logic [13:0]          mac_phase_o,
    output logic                 param_update_o,
    output logic                 late_o,
    output logic [LATE_W-1:0]    late_count_o,
    output logic [LVL_W-1:0]     queue_level_o,
    output logic                 busy_o
);
    typedef enum logic {EMPTY, ARMED} state_t;

    state_t             state_q, state_d;
    logic [47:0]        ts_q, ts_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [47:0]        st_mem_q [DEPTH];
    logic [47:0]        freq_mem_q [DEPTH];
    logic [13:0]        phase_mem_q [DEPTH];
    logic [47:0]        mac_to_q, mac_freq_q;
    logic [13:0]        mac_phase_q;
    logic               upd_q, late_q;
    logic [LATE_W-1:0]  late_cnt_q;
    logic               push, pop, is_late;

    // Ready depends only on registered level: a full queue refuses even if it pops this cycle.
    assign cmd.cmd_ready = (level_q != LVL_W'(DEPTH));
    assign is_late       = ts_q > st_mem_q[head_q];

    always_comb begin
        ts_d = ts_q;
        if (ts_clear_i)    ts_d = '0;
        else if (ts_run_i) ts_d = ts_q + 48'd1;
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        push    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            EMPTY:   pop = 1'b0;
            ARMED:   pop = ts_q >= st_mem_q[head_q];
            default: pop = 1'b0;
        endcase
        if (flush_i) begin
            pop     = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end else begin
            push = cmd.cmd_valid && cmd.cmd_ready;
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
        state_d = (level_d == '0) ? EMPTY : ARMED;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= EMPTY;
            ts_q        <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            level_q     <= '0;
            mac_to_q    <= '0;
            mac_freq_q  <= '0;
            mac_phase_q <= '0;
            upd_q       <= 1'b0;
            late_q      <= 1'b0;
            late_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            upd_q   <= pop;
            late_q  <= pop && is_late;
            if (pop) begin
                mac_to_q    <= st_mem_q[head_q];
                mac_freq_q  <= freq_mem_q[head_q];
                mac_phase_q <= phase_mem_q[head_q];
                if (is_late && (late_cnt_q != '1)) late_cnt_q <= late_cnt_q + LATE_W'(1);
            end
        end
    end

    // Entry storage needs no reset: slots are only read after being written.
    always_ff @(posedge clk_i) begin
        if (!reset_i && push) begin
            st_mem_q[tail_q]    <= cmd.cmd_start_time;
            freq_mem_q[tail_q]  <= cmd.cmd_freq;
            phase_mem_q[tail_q] <= cmd.cmd_phase;
        end
    end

    assign timestamp_o      = ts_q;
    assign mac_timeoffset_o = mac_to_q;
    assign mac_freq_o       = mac_freq_q;
    assign mac_phase_o      = mac_phase_q;
    assign param_update_o   = upd_q;
    assign late_o           = late_q;
    assign late_count_o     = late_cnt_q;
    assign queue_level_o    = level_q;
    assign busy_o           = (state_q == ARMED);
endmodule

// File: tb/tb_mac_param_scheduler.sv
// tb/tb_mac_param_scheduler.sv - directed self-checking bench for mac_param_scheduler
module tb_mac_param_scheduler;
    localparam int DEPTH  = 4;
    localparam int LATE_W = 4;

    logic              clk = 1'b0;
    logic              reset, ts_run, ts_clear, flush;
    logic [47:0]       timestamp, mac_timeoffset, mac_freq;
    logic [13:0]       mac_phase;
    logic              param_update, late, busy;
    logic [LATE_W-1:0] late_count;
    logic [2:0]        queue_level;
    int                tests = 0;
    int                errors = 0;

    mac_param_scheduler_if cmd_if();

    mac_param_scheduler #(.DEPTH(DEPTH), .LATE_W(LATE_W)) dut (
        .clk_i(clk), .reset_i(reset), .ts_run_i(ts_run), .ts_clear_i(ts_clear), .flush_i(flush),
        .cmd(cmd_if), .timestamp_o(timestamp), .mac_timeoffset_o(mac_timeoffset),
        .mac_freq_o(mac_freq), .mac_phase_o(mac_phase), .param_update_o(param_update),
        .late_o(late), .late_count_o(late_count), .queue_level_o(queue_level), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic v, input logic [47:0] st, input logic [47:0] f, input logic [13:0] ph);
        cmd_if.cmd_valid      = v;
        cmd_if.cmd_start_time = st;
        cmd_if.cmd_freq       = f;
        cmd_if.cmd_phase      = ph;
    endtask

    task automatic wait_update(input int max_cycles);
        int n = 0;
        while (!param_update && n < max_cycles) begin
            step();
            n++;
        end
        check("update_seen", {63'd0, param_update}, 64'd1);
    endtask

    initial begin
        reset = 1'b1; ts_run = 1'b0; ts_clear = 1'b0; flush = 1'b0;
        drive_cmd(1'b0, 48'd0, 48'd0, 14'd0);
        step(); step();
        check("rst_ready", {63'd0, cmd_if.cmd_ready}, 64'd1);
        check("rst_ts", timestamp, 64'd0);
        check("rst_level", queue_level, 64'd0);
        check("rst_busy", busy, 64'd0);
        check("rst_upd", param_update, 64'd0);
        check("rst_freq", mac_freq, 64'd0);
        check("rst_latecnt", late_count, 64'd0);

        // 1: on-time apply at st=100
        reset = 1'b0; ts_run = 1'b1;
        drive_cmd(1'b1, 48'd100, 48'h1000, 14'd5);
        step();
        drive_cmd(1'b0, 48'd0, 48'd0, 14'd0);
        check("t1_level", queue_level, 64'd1);
        check("t1_busy", busy, 64'd1);
        wait_update(200);
        check("t1_ts", timestamp, 64'd101);
        check("t1_freq", mac_freq, 64'h1000);
        check("t1_toff", mac_timeoffset, 64'd100);
        check("t1_phase", mac_phase, 64'd5);
        check("t1_late", late, 64'd0);
        check("t1_empty", queue_level, 64'd0);
        step();
        check("t1_pulse", param_update, 64'd0);
        check("t1_hold", mac_freq, 64'h1000);

        // 2: late apply, clear has priority over run
        ts_clear = 1'b1;
        step();
        ts_clear = 1'b0;
        check("t2_clear", timestamp, 64'd0);
        repeat (50) step();
        ts_run = 1'b0;
        check("t2_ts50", timestamp, 64'd50);
        drive_cmd(1'b1, 48'd10, 48'h2222, 14'd7);
        step();
        drive_cmd(1'b0, 48'd0, 48'd0, 14'd0);
        check("t2_noupd_yet", param_update, 64'd0);
        step();
        check("t2_upd", param_update, 64'd1);
        check("t2_late", late, 64'd1);
        check("t2_latecnt", late_count, 64'd1);
        check("t2_toff", mac_timeoffset, 64'd10);
        check("t2_phase", mac_phase, 64'd7);
        check("t2_hold_ts", timestamp, 64'd50);
        step();
        check("t2_late_pulse", late, 64'd0);

        // 3: fill queue, refuse 5th, FIFO drain
        for (int i = 0; i < DEPTH; i++) begin
            drive_cmd(1'b1, 48'd60 + 48'(i), 48'hA0 + 48'(i), 14'(i));
            step();
        end
        drive_cmd(1'b0, 48'd0, 48'd0, 14'd0);
        check("t3_full_ready", {63'd0, cmd_if.cmd_ready}, 64'd0);
        check("t3_full_level", queue_level, 64'd4);
        drive_cmd(1'b1, 48'd5, 48'hBAD, 14'd0);
        step();
        drive_cmd(1'b0, 48'd0, 48'd0, 14'd0);
        check("t3_5th_level", queue_level, 64'd4);
        check("t3_5th_noupd", param_update, 64'd0);
        ts_run = 1'b1;
        wait_update(50);
        check("t3_first_freq", mac_freq, 64'hA0);
        check("t3_first_ts", timestamp, 64'd61);
        check("t3_ready_back", {63'd0, cmd_if.cmd_ready}, 64'd1);
        check("t3_level3", queue_level, 64'd3);
        for (int i = 1; i < DEPTH; i++) begin
            step();
            check("t3_upd", param_update, 64'd1);
            check("t3_freq", mac_freq, 64'hA0 + 64'(i));
            check("t3_late", late, 64'd0);
        end
        check("t3_drained", queue_level, 64'd0);
        check("t3_idle", busy, 64'd0);
        ts_run = 1'b0;

        // 4: equal start times apply back to back, second late
        drive_cmd(1'b1, 48'd200, 48'hE0, 14'd1);
        step();
        drive_cmd(1'b1, 48'd200, 48'hF0, 14'd2);
        step();
        drive_cmd(1'b0, 48'd0, 48'd0, 14'd0);
        check("t4_level", queue_level, 64'd2);
        ts_run = 1'b1;
        wait_update(300);
        check("t4_a_freq", mac_freq, 64'hE0);
        check("t4_a_late", late, 64'd0);
        check("t4_a_ts", timestamp, 64'd201);
        step();
        ts_run = 1'b0;
        check("t4_b_upd", param_update, 64'd1);
        check("t4_b_freq", mac_freq, 64'hF0);
        check("t4_b_late", late, 64'd1);
        check("t4_latecnt", late_count, 64'd2);

        // 5: flush drops queue and same-cycle push, then cancels a pending pop
        for (int i = 0; i < 3; i++) begin
            drive_cmd(1'b1, 48'd5000 + 48'(i), 48'h500 + 48'(i), 14'd0);
            step();
        end
        drive_cmd(1'b1, 48'd6000, 48'h600, 14'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive_cmd(1'b0, 48'd0, 48'd0, 14'd0);
        check("t5_level", queue_level, 64'd0);
        check("t5_busy", busy, 64'd0);
        check("t5_noupd", param_update, 64'd0);
        check("t5_freq_hold", mac_freq, 64'hF0);
        drive_cmd(1'b1, 48'd0, 48'h700, 14'd3);
        step();
        drive_cmd(1'b0, 48'd0, 48'd0, 14'd0);
        check("t5_one", queue_level, 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t5_pop_cancel", param_update, 64'd0);
        check("t5_level2", queue_level, 64'd0);
        check("t5_freq_hold2", mac_freq, 64'hF0);

        // 6: 2^LATE_W+3 late applies saturate the counter, then reset mid-run
        drive_cmd(1'b1, 48'd0, 48'h800, 14'd0);
        repeat ((1 << LATE_W) + 3) step();
        drive_cmd(1'b0, 48'd0, 48'd0, 14'd0);
        repeat (3) step();
        check("t6_sat", late_count, 64'hF);
        check("t6_level", queue_level, 64'd0);
        check("t6_freq", mac_freq, 64'h800);
        ts_run = 1'b1;
        drive_cmd(1'b1, 48'd0, 48'h900, 14'd1);
        reset = 1'b1;
        step();
        check("t6_rst_ts", timestamp, 64'd0);
        check("t6_rst_freq", mac_freq, 64'd0);
        check("t6_rst_toff", mac_timeoffset, 64'd0);
        check("t6_rst_latecnt", late_count, 64'd0);
        check("t6_rst_level", queue_level, 64'd0);
        check("t6_rst_ready", {63'd0, cmd_if.cmd_ready}, 64'd1);
        reset = 1'b0;
        ts_run = 1'b0;
        drive_cmd(1'b0, 48'd0, 48'd0, 14'd0);
        step();
        check("t6_push_dropped", queue_level, 64'd0);
        check("t6_no_upd", param_update, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
